// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared AXI constants, FSM states and burst sizing for the DMAC read engine
package dmac_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA
  } dmac_state_t;

  // Beats-1 of the next burst: limited by words left, the burst cap and the next 4KB page edge.
  function automatic logic [3:0] calc_burst_len(
    input logic [11:0]  addr,
    input logic [31:0]  remaining,
    input int unsigned  max_beats,
    input int unsigned  beat_shift
  );
    logic [31:0] to_bound;
    logic [31:0] n;
    to_bound = (32'd4096 - {20'd0, addr}) >> beat_shift;
    n = remaining;
    if (n > max_beats) n = max_beats;
    if (n > to_bound)  n = to_bound;
    return 4'(n - 32'd1);
  endfunction

endpackage

// File: rtl/dmac_rd_engine.sv
// rtl/dmac_rd_engine.sv - AXI4 read master splitting a byte transfer into INCR bursts feeding the data FIFO
module dmac_rd_engine
  import dmac_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [LEN_WIDTH-1:0]  byte_len_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [3:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_wren_o,
  output logic [DATA_WIDTH-1:0] fifo_wdata_o
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  dmac_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [4:0]            beat_cnt;
  logic                  err_q;
  logic [3:0]            burst_len;
  logic [4:0]            burst_beats;
  logic                  start_ok;
  logic                  ar_hs;
  logic                  r_hs;

  assign burst_len   = calc_burst_len(addr_q[11:0], 32'(rem_q), MAX_BURST, BEAT_SHIFT);
  assign burst_beats = {1'b0, burst_len} + 5'd1;

  assign start_ok = (state == ST_IDLE) && start_i && (byte_len_i != '0);
  assign ar_hs    = (state == ST_REQ) && arready_i;
  assign r_hs     = (state == ST_DATA) && rvalid_i && !fifo_full_i;

  assign done_o       = (state == ST_IDLE);
  assign err_o        = err_q;
  assign araddr_o     = addr_q;
  assign arlen_o      = burst_len;
  assign arsize_o     = 3'(BEAT_SHIFT);
  assign arburst_o    = BURST_INCR;
  assign arvalid_o    = (state == ST_REQ);
  assign rready_o     = (state == ST_DATA) && !fifo_full_i;
  assign fifo_wren_o  = r_hs;
  assign fifo_wdata_o = rdata_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_REQ;
      ST_REQ:  if (arready_i) state_nxt = ST_DATA;
      ST_DATA: if (r_hs && beat_cnt == 5'd1) state_nxt = (rem_q != '0) ? ST_REQ : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        addr_q <= src_addr_i;
        rem_q  <= byte_len_i >> BEAT_SHIFT;
        err_q  <= 1'b0;
      end
      if (ar_hs) begin
        beat_cnt <= burst_beats;
        addr_q   <= addr_q + (ADDR_WIDTH'(burst_beats) << BEAT_SHIFT);
        rem_q    <= rem_q - LEN_WIDTH'(burst_beats);
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt - 5'd1;
        if (rresp_i != RESP_OKAY) err_q <= 1'b1;
      end
    end
  end

  // The beat counter, not rlast, ends a burst; a disagreeing slave is flagged here.
  always_ff @(posedge clk) begin
    if (rst_n && r_hs) assert (rlast_i == (beat_cnt == 5'd1));
  end

endmodule

// File: tb/tb_dmac_rd_engine.sv
// tb/tb_dmac_rd_engine.sv - directed bench for dmac_rd_engine with a one-burst AXI read slave
module tb_dmac_rd_engine;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] src_addr_i;
  logic [LW-1:0] byte_len_i;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] araddr_o;
  logic [3:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          arvalid_o;
  logic          arready_i;
  logic [DW-1:0] rdata_i;
  logic [1:0]    rresp_i;
  logic          rlast_i;
  logic          rvalid_i;
  logic          rready_o;
  logic          fifo_full_i;
  logic          fifo_wren_o;
  logic [DW-1:0] fifo_wdata_o;

  always #5 clk = ~clk;

  dmac_rd_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
    .byte_len_i(byte_len_i), .done_o(done_o), .err_o(err_o), .araddr_o(araddr_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o),
    .arready_i(arready_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .fifo_full_i(fifo_full_i),
    .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] ar_addr_q[$];
  logic [3:0]  ar_len_q[$];
  logic [31:0] push_q[$];
  int          done_cyc, last_push_cyc, err_hs_cyc, err_first_cyc;
  int          stall_bad, wren_bad, hit_rst;
  logic        done_at2, err_at2;

  // One transfer: slave answers one burst at a time; windows are counted in data cycles.
  task automatic run(input logic [31:0] src, input logic [15:0] len, input int full_lo,
                     input int full_hi, input int err_beat, input int mid_start, input int rst_at);
    int cyc, dcyc, beat, blen, bidx;
    logic bact;
    logic [31:0] baddr;
    ar_addr_q.delete(); ar_len_q.delete(); push_q.delete();
    cyc = 0; dcyc = 0; beat = 0; blen = 0; bidx = 0; bact = 1'b0; baddr = '0;
    done_cyc = -1; last_push_cyc = -1; err_hs_cyc = -1; err_first_cyc = -1;
    stall_bad = 0; wren_bad = 0; hit_rst = 0; done_at2 = 1'bx; err_at2 = 1'bx;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bact) dcyc++;
      start_i = (cyc == 1);
      if (cyc == 1) begin src_addr_i = src; byte_len_i = len; end
      if (mid_start != 0 && bact && dcyc == mid_start) begin
        start_i = 1'b1; src_addr_i = 32'h0000_8000; byte_len_i = 16'd64;
      end
      arready_i   = 1'b1;
      rvalid_i    = bact;
      rdata_i     = bact ? beat_data(baddr) : '0;
      rlast_i     = bact && (bidx == blen);
      rresp_i     = (bact && beat + 1 == err_beat) ? 2'b10 : 2'b00;
      fifo_full_i = bact && dcyc >= full_lo && dcyc <= full_hi;
      if (rst_at != 0 && bact && dcyc == rst_at) begin
        rst_n = 1'b0;
        hit_rst = 1;
        break;
      end
      #1;
      if (cyc == 2) begin done_at2 = done_o; err_at2 = err_o; end
      if (cyc >= 2 && err_o && err_first_cyc < 0) err_first_cyc = cyc;
      if (fifo_wren_o !== (rvalid_i & ~fifo_full_i)) wren_bad++;
      if (fifo_full_i && (rready_o || fifo_wren_o)) stall_bad++;
      if (rvalid_i && rready_o) begin
        push_q.push_back(fifo_wdata_o);
        beat++;
        last_push_cyc = cyc;
        if (rresp_i != 2'b00) err_hs_cyc = cyc;
        baddr = baddr + 32'd4;
        if (bidx == blen) bact = 1'b0;
        else bidx++;
      end
      if (arvalid_o && arready_i) begin
        ar_addr_q.push_back(araddr_o);
        ar_len_q.push_back(arlen_o);
        bact = 1'b1; baddr = araddr_o; blen = int'(arlen_o); bidx = 0;
      end
      if (cyc > 1 && done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    start_i = 1'b0;
    if (!hit_rst) begin
      rvalid_i = 1'b0; fifo_full_i = 1'b0; rlast_i = 1'b0;
    end
    check("run_finished", 64'(done_cyc > 0 || hit_rst == 1), 64'd1);
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [3:0] l);
    logic [31:0] ga;
    logic [3:0]  gl;
    ga = (idx < ar_addr_q.size()) ? ar_addr_q[idx] : 32'hxxxx_xxxx;
    gl = (idx < ar_len_q.size()) ? ar_len_q[idx] : 4'hx;
    check({tag, "_araddr"}, 64'(ga), 64'(a));
    check({tag, "_arlen"}, 64'(gl), 64'(l));
  endtask

  task automatic check_pushes(input string tag, input logic [31:0] src, input int n);
    int bad;
    bad = 0;
    check({tag, "_push_count"}, 64'(push_q.size()), 64'(n));
    for (int i = 0; i < n && i < push_q.size(); i++)
      if (push_q[i] !== beat_data(src + 32'(i * 4))) bad++;
    check({tag, "_push_data_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; src_addr_i = '0; byte_len_i = '0; arready_i = 1'b0;
    rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0; fifo_full_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", 64'(done_o), 64'd1);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_arvalid", 64'(arvalid_o), 64'd0);
    check("rst_rready", 64'(rready_o), 64'd0);
    check("rst_wren", 64'(fifo_wren_o), 64'd0);
    check("arsize", 64'(arsize_o), 64'd2);
    check("arburst", 64'(arburst_o), 64'd1);
    rst_n = 1'b1;

    run(32'h0000_1000, 16'd16, 0, -1, 0, 0, 0);
    check("t1_ar_count", 64'(ar_addr_q.size()), 64'd1);
    check_ar("t1_ar0", 0, 32'h0000_1000, 4'd3);
    check_pushes("t1", 32'h0000_1000, 4);
    check("t1_done_drop", 64'(done_at2), 64'd0);
    check("t1_done_latency", 64'(done_cyc - last_push_cyc), 64'd1);

    run(32'h0000_0000, 16'd80, 0, -1, 0, 0, 0);
    check("t2_ar_count", 64'(ar_addr_q.size()), 64'd2);
    check_ar("t2_ar0", 0, 32'h0000_0000, 4'd15);
    check_ar("t2_ar1", 1, 32'h0000_0040, 4'd3);
    check_pushes("t2", 32'h0000_0000, 20);

    run(32'h0000_0FF8, 16'd32, 0, -1, 0, 0, 0);
    check("t3_ar_count", 64'(ar_addr_q.size()), 64'd2);
    check_ar("t3_ar0", 0, 32'h0000_0FF8, 4'd1);
    check_ar("t3_ar1", 1, 32'h0000_1000, 4'd5);
    check_pushes("t3", 32'h0000_0FF8, 8);

    run(32'h0000_2000, 16'd16, 2, 6, 0, 0, 0);
    check_pushes("t4", 32'h0000_2000, 4);
    check("t4_stall_bad", 64'(stall_bad), 64'd0);
    check("t4_wren_bad", 64'(wren_bad), 64'd0);

    run(32'h0000_6000, 16'd16, 0, -1, 2, 0, 0);
    check_pushes("t5", 32'h0000_6000, 4);
    check("t5_err_latency", 64'(err_first_cyc - err_hs_cyc), 64'd1);
    check("t5_err_sticky", 64'(err_o), 64'd1);
    check("t5_done", 64'(done_o), 64'd1);

    run(32'h0000_5000, 16'd8, 0, -1, 0, 0, 0);
    check("t6_err_cleared", 64'(err_at2), 64'd0);
    check("t6_err_final", 64'(err_o), 64'd0);
    check_pushes("t6", 32'h0000_5000, 2);

    run(32'h0000_7000, 16'd0, 0, -1, 0, 0, 0);
    check("t7_no_ar", 64'(ar_addr_q.size()), 64'd0);
    check("t7_done_stays", 64'(done_cyc), 64'd2);

    run(32'h0000_3000, 16'd16, 0, -1, 0, 2, 0);
    check("t8_ar_count", 64'(ar_addr_q.size()), 64'd1);
    check_ar("t8_ar0", 0, 32'h0000_3000, 4'd3);
    check_pushes("t8", 32'h0000_3000, 4);

    run(32'h0000_4000, 16'd64, 0, -1, 0, 0, 3);
    @(negedge clk);
    rvalid_i = 1'b0; rlast_i = 1'b0; fifo_full_i = 1'b0;
    #1;
    check("t9_rst_seen", 64'(hit_rst), 64'd1);
    check("t9_arvalid", 64'(arvalid_o), 64'd0);
    check("t9_rready", 64'(rready_o), 64'd0);
    check("t9_done", 64'(done_o), 64'd1);
    rst_n = 1'b1;

    run(32'h0000_9000, 16'd8, 0, -1, 0, 0, 0);
    check_ar("t10_ar0", 0, 32'h0000_9000, 4'd1);
    check_pushes("t10", 32'h0000_9000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_rd_engine.md
Name: dmac_rd_engine

Overview:
- AXI4 read-master stage directly upstream of the DMAC data FIFO.
- On a start pulse it splits a byte-length transfer into INCR bursts, issues AR requests, and accepts R beats.
- Each accepted beat is pushed into the FIFO write port; R is back-pressured by FIFO full.
- The FIFO drain side (write engine) lives elsewhere.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data and FIFO data width; beat size = DATA_WIDTH/8 bytes.
- LEN_WIDTH, 16, width of the transfer byte-length field.
- MAX_BURST, 16, maximum beats per burst; power of 2, 1..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  1-cycle start pulse; sampled only in IDLE
- src_addr_i  in  ADDR_WIDTH  source byte address; beat-aligned
- byte_len_i  in  LEN_WIDTH  transfer length in bytes; multiple of beat size
- done_o  out  1  high while IDLE
- err_o  out  1  sticky: a non-OKAY RRESP was seen during the current transfer
- araddr_o  out  ADDR_WIDTH  burst start address
- arlen_o  out  4  beats-1
- arsize_o  out  3  log2(DATA_WIDTH/8), constant
- arburst_o  out  2  2'b01 INCR, constant
- arvalid_o  out  1  AR valid
- arready_i  in  1  AR ready
- rdata_i  in  DATA_WIDTH  read data
- rresp_i  in  2  read response
- rlast_i  in  1  last beat of burst
- rvalid_i  in  1  R valid
- rready_o  out  1  R ready
- fifo_full_i  in  1  FIFO full
- fifo_wren_o  out  1  FIFO push
- fifo_wdata_o  out  DATA_WIDTH  FIFO push data

Behaviour:
- Reset values: state IDLE, done_o=1, err_o=0, arvalid_o=0, rready_o=0, fifo_wren_o=0, internal addr/remaining/beat counters 0.
- Reset mid-transfer aborts immediately. Outstanding AXI beats are the system's responsibility.
- FSM states: IDLE, REQ, DATA.
- IDLE:
  - start_i with byte_len_i != 0 latches addr and remaining words (byte_len_i / beat size), clears err_o, and moves to REQ next cycle.
  - start_i with byte_len_i == 0 is ignored; done_o stays 1.
- REQ:
  - arvalid_o=1.
  - arlen_o = min(remaining, MAX_BURST, beats to next 4KB boundary) - 1, computed combinationally from the latched addr/remaining.
  - araddr_o, arlen_o and arvalid_o stay stable until arready_i.
  - On arvalid_o & arready_i: load beat counter with arlen_o+1, advance addr by (arlen_o+1)*beat size, subtract arlen_o+1 from remaining, go to DATA.
  - One outstanding burst only.
- DATA:
  - rready_o = ~fifo_full_i (combinational).
  - fifo_wren_o = rvalid_i & rready_o; fifo_wdata_o = rdata_i. Push happens in the same cycle as the R handshake, zero latency.
  - No beat is ever dropped or duplicated; a full FIFO simply stalls R.
  - Each handshake decrements the beat counter.
  - rresp_i != 2'b00 on a handshake sets err_o. err_o is sticky until the next accepted start, and the transfer continues.
  - On the handshake with beat counter == 1: go to REQ if remaining != 0, else IDLE.
  - rlast_i is not used for control. A mismatch between rlast_i and the beat counter is a simulation assertion error.
- Outside DATA: rready_o=0 and fifo_wren_o=0.
- Bursts never cross a 4KB boundary.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- done_o drops the cycle after an accepted start and returns high the cycle after the final beat.

Decomposition:
- Shared package dmac_pkg holds:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - FSM state enum.
  - Function calc_burst_len(addr, remaining, max), returning beats-1.
- No sub-module; the FIFO is instantiated by the parent alongside this engine.

Test Plan:
- Single short transfer: src=0x1000, len=16 (4 beats), arready and rvalid always high, FIFO never full -> one AR with araddr=0x1000, arlen=3; 4 fifo pushes of rdata in order; done_o high again 1 cycle after the 4th beat.
- Burst split: src=0x0, len=80 (20 beats), MAX_BURST=16 -> AR1 arlen=15 @0x0, AR2 arlen=3 @0x40; 20 pushes total.
- 4KB boundary: src=0x0FF8, len=32 (8 beats) -> AR1 @0x0FF8 arlen=1, AR2 @0x1000 arlen=5.
- Back-pressure: fifo_full_i held high for cycles 2..6 of DATA while rvalid_i=1 -> rready_o=0 and fifo_wren_o=0 on those cycles; rdata_i is held and pushed exactly once after full drops; no lost beats.
- Error plus restart: rresp=2'b10 on beat 2 of 4 -> err_o=1 from the next cycle, all 4 beats still pushed, done_o=1. A new start clears err_o to 0.
- Edge cases:
  - start with len=0 -> no AR, done_o stays 1.
  - start_i pulsed while in DATA -> ignored.
  - rst_n low mid-DATA -> next cycle arvalid_o=0, rready_o=0, done_o=1.
